// File: rtl/hourglass_turn_sequencer.sv
// Replays a stored program of turn commands into the hourglass puzzle and
// reports a single pass / failed / timeout / empty verdict per run.
module hourglass_turn_sequencer #(
  parameter  int MSB        = 15,
  parameter  int DEPTH      = 16,
  parameter  int STEP_LIMIT = 100,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [1:0]    prog_data,
  input  logic          start,
  input  logic [MSB:0]  target,
  input  logic [AW:0]   len,
  input  logic          done,
  input  logic          failed,
  output logic [MSB:0]  startTime,
  output logic          puzzle_restart,
  output logic          turnSmall,
  output logic          turnLarge,
  output logic          busy,
  output logic          result_valid,
  output logic [1:0]    result_code,
  output logic [7:0]    steps
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_REPORT} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [7:0]  LIMIT_L = 8'(STEP_LIMIT);

  localparam logic [1:0] CODE_PASS    = 2'b00;
  localparam logic [1:0] CODE_FAILED  = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT = 2'b10;
  localparam logic [1:0] CODE_EMPTY   = 2'b11;

  logic [1:0] mem [DEPTH];

  state_t      state_q, state_d;
  logic [MSB:0] start_time_q, start_time_d;
  logic [AW:0] len_q, len_d;
  logic [AW:0] pc_q, pc_d;
  logic [7:0]  steps_q, steps_d;
  logic [1:0]  turn_q, turn_d;
  logic        restart_q, restart_d;
  logic        busy_q, busy_d;
  logic        rv_q, rv_d;
  logic [1:0]  code_q, code_d;
  logic [7:0]  steps_inc;
  logic [AW:0] len_clamped;

  // Program memory deliberately survives reset so a run can be replayed.
  always_ff @(posedge clock) begin
    if (state_q == S_IDLE && prog_we)
      mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      start_time_q <= '0;
      len_q        <= '0;
      pc_q         <= '0;
      steps_q      <= '0;
      turn_q       <= '0;
      restart_q    <= 1'b0;
      busy_q       <= 1'b0;
      rv_q         <= 1'b0;
      code_q       <= '0;
    end else begin
      state_q      <= state_d;
      start_time_q <= start_time_d;
      len_q        <= len_d;
      pc_q         <= pc_d;
      steps_q      <= steps_d;
      turn_q       <= turn_d;
      restart_q    <= restart_d;
      busy_q       <= busy_d;
      rv_q         <= rv_d;
      code_q       <= code_d;
    end
  end

  assign steps_inc   = (steps_q == 8'hFF) ? steps_q : steps_q + 8'd1;
  assign len_clamped = (len > DEPTH_L) ? DEPTH_L : len;

  // Outputs are registered: values computed here appear one cycle later.
  always_comb begin
    state_d      = state_q;
    start_time_d = start_time_q;
    len_d        = len_q;
    pc_d         = pc_q;
    steps_d      = steps_q;
    turn_d       = 2'b00;
    restart_d    = 1'b0;
    busy_d       = 1'b0;
    rv_d         = 1'b0;
    code_d       = code_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len == '0) begin
            state_d = S_REPORT;
            steps_d = '0;
            code_d  = CODE_EMPTY;
            rv_d    = 1'b1;
          end else begin
            state_d      = S_RUN;
            start_time_d = target;
            len_d        = len_clamped;
            pc_d         = (AW+1)'(1);
            steps_d      = '0;
            turn_d       = mem[0];
            restart_d    = 1'b1;
            busy_d       = 1'b1;
          end
        end
      end
      S_RUN: begin
        steps_d = steps_inc;
        busy_d  = 1'b1;
        if (failed || done || steps_inc == LIMIT_L) begin
          state_d = S_REPORT;
          rv_d    = 1'b1;
          code_d  = failed ? CODE_FAILED : (done ? CODE_PASS : CODE_TIMEOUT);
        end else if (pc_q < len_q) begin
          turn_d = mem[pc_q[AW-1:0]];
          pc_d   = pc_q + (AW+1)'(1);
        end
      end
      S_REPORT: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign startTime      = start_time_q;
  assign puzzle_restart = restart_q;
  assign turnSmall      = turn_q[0];
  assign turnLarge      = turn_q[1];
  assign busy           = busy_q;
  assign result_valid   = rv_q;
  assign result_code    = code_q;
  assign steps          = steps_q;

endmodule

// File: tb/tb_hourglass_turn_sequencer.sv
// Directed bench for hourglass_turn_sequencer; done/failed are driven by hand.
module tb_hourglass_turn_sequencer;

  localparam int MSB = 15;
  localparam int DEPTH = 16;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [1:0]    prog_data;
  logic          start;
  logic [MSB:0]  target;
  logic [AW:0]   len;
  logic          done;
  logic          failed;
  logic [MSB:0]  startTime;
  logic          puzzle_restart;
  logic          turnSmall;
  logic          turnLarge;
  logic          busy;
  logic          result_valid;
  logic [1:0]    result_code;
  logic [7:0]    steps;

  int n_checks = 0;
  int n_fail = 0;

  hourglass_turn_sequencer #(.MSB(MSB), .DEPTH(DEPTH), .STEP_LIMIT(100)) dut (
    .clock(clock), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .target(target), .len(len),
    .done(done), .failed(failed), .startTime(startTime),
    .puzzle_restart(puzzle_restart), .turnSmall(turnSmall), .turnLarge(turnLarge),
    .busy(busy), .result_valid(result_valid), .result_code(result_code),
    .steps(steps)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic kick(input logic [MSB:0] t, input logic [AW:0] l);
    target = t;
    len = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    start = 1'b0; target = '0; len = '0; done = 1'b0; failed = 1'b0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_rv", result_valid, 0);
    check("rst_code", result_code, 0);
    check("rst_steps", steps, 0);
    check("rst_starttime", startTime, 0);
    check("rst_turn", {turnLarge, turnSmall}, 0);
    check("rst_restart", puzzle_restart, 0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      prog_we = 1'b1; prog_addr = AW'(i); prog_data = 2'(i);
      tick();
    end
    prog_we = 1'b0;

    // pass in RUN cycle 1
    kick(16'd0, 5'd1);
    check("A_busy", busy, 1);
    check("A_restart", puzzle_restart, 1);
    check("A_turn", {turnLarge, turnSmall}, 0);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("A_rv", result_valid, 1);
    check("A_code", result_code, 0);
    check("A_steps", steps, 1);
    check("A_busy_report", busy, 1);
    tick();
    check("A_busy_idle", busy, 0);
    check("A_rv_off", result_valid, 0);

    // failed wins over done
    kick(16'd3, 5'd1);
    check("B_starttime", startTime, 3);
    failed = 1'b1; done = 1'b1;
    tick();
    failed = 1'b0; done = 1'b0;
    check("B_rv", result_valid, 1);
    check("B_code", result_code, 1);
    check("B_steps", steps, 1);
    check("B_starttime_rep", startTime, 3);
    tick();
    check("B_starttime_idle", startTime, 3);

    // timeout
    kick(16'd1000, 5'd1);
    tick();
    check("C_turn_c2", {turnLarge, turnSmall}, 0);
    check("C_restart_c2", puzzle_restart, 0);
    n = 1;
    while (!result_valid && n < 200) begin
      tick();
      n++;
    end
    check("C_latency", n, 100);
    check("C_code", result_code, 2);
    check("C_steps", steps, 100);
    tick();

    // turn sequence follows the program, then zero
    kick(16'd50, 5'd4);
    for (int k = 0; k < 4; k++) begin
      check("D_turn", {turnLarge, turnSmall}, k);
      tick();
    end
    check("D_turn_end", {turnLarge, turnSmall}, 0);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("D_code", result_code, 0);
    check("D_steps", steps, 5);
    tick();

    // empty program
    kick(16'd77, 5'd0);
    check("E_rv", result_valid, 1);
    check("E_code", result_code, 3);
    check("E_busy", busy, 0);
    check("E_steps", steps, 0);
    check("E_starttime", startTime, 50);
    tick();
    check("E_rv_off", result_valid, 0);
    check("E_busy_after", busy, 0);

    // prog_we and start ignored during RUN
    kick(16'd7, 5'd1);
    prog_we = 1'b1; prog_addr = '0; prog_data = 2'b11;
    target = 16'd9; start = 1'b1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    check("F_starttime", startTime, 7);
    check("F_restart", puzzle_restart, 0);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("F_code", result_code, 0);
    check("F_steps", steps, 2);
    tick();
    kick(16'd20, 5'd1);
    check("F_mem0", {turnLarge, turnSmall}, 0);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();

    // reset mid-run, then replay
    kick(16'd40, 5'd4);
    tick();
    check("G_turn_c2", {turnLarge, turnSmall}, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("G_busy", busy, 0);
    check("G_rv", result_valid, 0);
    check("G_starttime", startTime, 0);
    check("G_turn", {turnLarge, turnSmall}, 0);
    check("G_steps", steps, 0);
    n = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (result_valid) n++;
    end
    check("G_no_verdict", n, 0);
    kick(16'd5, 5'd4);
    check("G_replay0", {turnLarge, turnSmall}, 0);
    check("G_replay_restart", puzzle_restart, 1);
    tick();
    check("G_replay1", {turnLarge, turnSmall}, 1);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("G_code", result_code, 0);
    check("G_steps_final", steps, 2);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hourglass_turn_sequencer.md
# hourglass_turn_sequencer

Programmable stimulus sequencer directly upstream of the hourglass puzzle model. It holds a small program of per-event turn commands, drives the puzzle's `startTime`, `turnSmall` and `turnLarge` inputs, and watches the puzzle's `done` and `failed` outputs. It reports a single pass/fail/timeout verdict per run. Bench and formal harnesses use it to replay candidate turn schedules against target intervals.

## Interface
Parameters:
- `MSB`, 15, MSB of `target`/`startTime`; matches the puzzle's `MSB`.
- `DEPTH`, 16, number of program entries; `AW = $clog2(DEPTH)`.
- `STEP_LIMIT`, 100, maximum RUN cycles before a timeout verdict; must be < 256.

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  rising-edge clock, shared with the puzzle.
- `reset`  in  1  synchronous, active-high.
- `prog_we`  in  1  program write strobe; honoured only in IDLE.
- `prog_addr`  in  AW  program write address.
- `prog_data`  in  2  bit0 = turn small, bit1 = turn large.
- `start`  in  1  begin a run; honoured only in IDLE.
- `target`  in  MSB+1  interval to measure; latched on start.
- `len`  in  AW+1  number of program entries to play, 0..DEPTH; latched on start.
- `done`  in  1  from puzzle: elapsed == 0.
- `failed`  in  1  from puzzle: elapsed in {1,2,3,5,6}.
- `startTime`  out  MSB+1  latched target, held stable for the whole run.
- `puzzle_restart`  out  1  one-cycle pulse, the first RUN cycle; the puzzle reloads `startTime` on it.
- `turnSmall`, `turnLarge`  out  1 each  current program entry's bits.
- `busy`  out  1  high in RUN and REPORT.
- `result_valid`  out  1  one-cycle verdict strobe.
- `result_code`  out  2  00 pass, 01 failed, 10 timeout, 11 empty program.
- `steps`  out  8  RUN cycles consumed; held until the next start.

## Operation
- States: IDLE, RUN, REPORT.
- IDLE:
  - `prog_we` writes `prog_data` to `mem[prog_addr]`.
  - On `start` with `len`>0: latch `target` into `startTime` and `len`; clear `pc` and `steps`; go to RUN.
  - On `start` with `len`==0: go to REPORT with code 11 and `steps`=0.
  - `len` > DEPTH is clamped to DEPTH.
- RUN, each cycle:
  - While `pc` < `len`: `turnSmall`/`turnLarge` = `mem[pc]` bits, then `pc`++. Once `pc` == `len`, both turn outputs are 0.
  - `steps`++, saturating at 255.
  - Sample `done`/`failed` every RUN cycle, including the first.
  - Verdict priority: `failed` (01) > `done` (00) > `steps` reaching `STEP_LIMIT` (10). The first hit moves to REPORT.
- REPORT: `result_valid`=1 for exactly one cycle with the stored code; turn outputs 0; next state is IDLE.
- `prog_we` and `start` are ignored outside IDLE. Program memory is never cleared by reset.
- `startTime` holds its value in IDLE after a run; it changes only on an accepted start.

## Timing
- Reset values: state IDLE; `startTime`=0, turn outputs 0, `puzzle_restart`=0, `busy`=0, `result_valid`=0, `result_code`=0, `steps`=0, `pc`=0.
- Reset asserted mid-run forces these values on the next edge; no verdict is issued.
- `start` accepted at edge t:
  - RUN begins at t+1: `busy`=1, `puzzle_restart`=1, turn outputs = `mem[0]`.
  - Turn outputs and `puzzle_restart` are registered.
- Condition seen in RUN cycle k: `result_valid` at k+1; `busy` falls at k+2. `steps` equals k counted from 1.
- Timeout: `steps` reaches `STEP_LIMIT` at RUN cycle `STEP_LIMIT`; `result_valid` follows one cycle later.
- Empty program: `start` at t gives `result_valid` at t+1 with code 11.
- Back-to-back runs: the earliest accepted next `start` is the IDLE cycle after REPORT.

## Test plan
- target=0, len=1, mem[0]=00, start -> `done` in RUN cycle 1 -> `result_valid` with code 00, `steps`=1.
- target=3, len=1, start -> `failed` in RUN cycle 1 -> code 01, `steps`=1; `startTime`=3 throughout.
- target=1000, len=1, mem[0]=00 (puzzle never progresses) -> code 10 exactly at `steps`=100; turn outputs 0 from RUN cycle 2.
- len=0, start -> `result_valid` next cycle with code 11, `busy` never high.
- During RUN, pulse `prog_we` (addr 0, data 11) and `start` with target=9 -> memory and `startTime` unchanged; the run completes with the original target.
- Program 4 entries, assert `reset` at RUN cycle 2 -> all outputs at reset values next cycle, no `result_valid`. A subsequent start replays the same retained program from entry 0.
